priority_scan_encoder: RTL and testbench
========================================

Name: priority_scan_encoder

Overview:
Sequential, parametrised successor to the team's combinational N-bit priority encoder. Accepts a 2**N-bit request vector over a valid/ready handshake. Emits the index of every set bit, one per accepted output beat, in a selectable priority order (LSB-first or MSB-first). Used wherever a request mask must be serviced one index at a time, such as interrupt enumeration and multi-channel dispatch.

Parameters:
N, 3, index width; request vector width is 2**N
MSB_FIRST, 0, 0 = lowest set bit emitted first; 1 = highest set bit first

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  global enable; low freezes the block (see Behaviour)
in  input  2**N  request vector
load_valid  input  1  in is valid
load_ready  output  1  block can accept a vector
out  output  N  current index
out_valid  output  1  out is valid
out_ready  input  1  consumer accepts out
out_last  output  1  out is the final set bit of the current vector
count  output  N+1  popcount of the last accepted vector, registered
zero  output  1  one-cycle pulse: accepted vector was all-zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, pending=0, count=0, zero=0. Consequently out_valid=0, out_last=0, out=0, load_ready=1 (when enable=1).
- FSM states:
  - IDLE: load_ready = enable.
  - SCAN: out_valid = enable.
- Load: on a clock edge with load_valid && load_ready:
  - pending <= in; count <= popcount(in).
  - If in != 0: state -> SCAN, so out_valid rises the next cycle (latency 1).
  - If in == 0: zero=1 for exactly the next cycle, state stays IDLE, out_valid never asserts.
- out is derived combinationally from the registered pending vector:
  - MSB_FIRST=0: index of the lowest set bit.
  - MSB_FIRST=1: index of the highest set bit.
  - out=0 when pending=0.
- out_last = out_valid && (pending has exactly one bit set).
- Output beat: on out_valid && out_ready, the bit at index out is cleared in pending.
  - If out_last: state -> IDLE.
  - Otherwise: stay in SCAN; the next index is presented the following cycle.
- Backpressure: while out_valid && !out_ready, out, out_last and pending hold stable.
- Back-to-back loads: in SCAN, load_ready = enable && out_last && out_ready. A load accepted on the last beat moves directly to SCAN (or to the zero pulse for a zero vector) with no idle cycle.
- enable=0:
  - load_ready=0 and out_valid=0.
  - state, pending and count hold; no handshakes complete.
  - zero still completes its pulse.
  - Scanning resumes unchanged when enable returns high.
- Async reset mid-SCAN: immediately returns to the reset values; the partially scanned vector is discarded.
- in is sampled only on the load handshake; changes at any other time are ignored.
- Width rule: count is N+1 bits so that popcount = 2**N (all bits set) fits.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=1'b0, SCAN=1'b1);
  - constant function for vector width (2**N);
  - popcount function.
- Sub-module prio_index:
  - purely combinational, parameters N and MSB_FIRST;
  - inputs: vec [2**N-1:0];
  - outputs: idx [N-1:0], any;
  - instantiated once on pending.

Test Plan:
1. N=3, MSB_FIRST=0, out_ready=1, load in=8'b1010_0100 at cycle t -> out=2,5,7 on cycles t+1,t+2,t+3; out_last only on 7; count=3; IDLE at t+4.
2. MSB_FIRST=1, same vector -> out=7,5,2; out_last on 2.
3. Load in=8'h00 -> zero=1 for one cycle, out_valid stays 0, load_ready stays 1, count=0.
4. Load 8'b0001_0001, hold out_ready=0 for 3 cycles -> out=0 and out_valid=1 stable throughout; then out_ready=1 -> 0 then 4; out_last on 4.
5. Load 8'h01, then present 8'h80 with load_valid held high -> load accepted on the out_last beat; out=0 then out=7 on consecutive cycles with no idle gap.
6. Load 8'hFF, accept 2 beats, then:
   - drop enable for 2 cycles -> out_valid=0 and pending holds; on re-enable out=2 and count=8.
   - assert rst mid-scan -> out_valid=0 and load_ready=1 immediately; pending=0.

Source files
------------

// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Covers the state encoding, the vector width and the popcount.
package priority_scan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Widest request vector the popcount helper handles (N up to 8).
  localparam int unsigned MAX_W = 256;

  function automatic int unsigned vec_width(input int unsigned n);
    return 32'(1) << n;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/priority_scan_encoder_prio.sv
// Combinational priority index of a request vector.
// Selects the lowest set bit, or the highest set bit when MSB_FIRST is nonzero.
module prio_index
  import priority_scan_encoder_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic [vec_width(N)-1:0] vec,
  output logic [N-1:0]            idx,
  output logic                    any
);

  localparam int unsigned W = vec_width(N);

  // The last matching bit in scan order wins, so the scan direction sets priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < int'(W); i++) begin
        if (vec[i]) idx = N'(i);
      end
    end else begin
      for (int i = int'(W) - 1; i >= 0; i--) begin
        if (vec[i]) idx = N'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/priority_scan_encoder.sv
// Accepts a request vector over valid/ready and emits the index of each set bit,
// one per output beat, in LSB-first or MSB-first order.
module priority_scan_encoder
  import priority_scan_encoder_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [vec_width(N)-1:0] in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [N-1:0]            out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [N:0]              count,
  output logic                    zero
);

  localparam int unsigned W = vec_width(N);

  state_t         state_q, state_d;
  logic [W-1:0]   pending_q, pending_d;
  logic [N:0]     count_q, count_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   idx;
  logic           any;
  logic           single;
  logic           load_fire;
  logic           beat_fire;

  prio_index #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_index (
    .vec (pending_q),
    .idx (idx),
    .any (any)
  );

  // Exactly one bit left in the pending vector.
  assign single = any && ((pending_q & (pending_q - W'(1))) == '0);

  assign out        = idx;
  assign out_valid  = enable && (state_q == SCAN);
  assign out_last   = out_valid && single;
  assign load_ready = enable && ((state_q == IDLE) || (out_last && out_ready));
  assign count      = count_q;
  assign zero       = zero_q;

  assign load_fire = load_valid && load_ready;
  assign beat_fire = out_valid && out_ready;

  // A load on the final beat overrides the beat's clear and state change.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;
    if (beat_fire) begin
      pending_d = pending_q & ~(W'(1) << idx);
      if (out_last) state_d = IDLE;
    end
    if (load_fire) begin
      pending_d = in;
      count_d   = (N+1)'(popcount(MAX_W'(in)));
      if (in != '0) begin
        state_d = SCAN;
      end else begin
        state_d = IDLE;
        zero_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed table-driven bench for priority_scan_encoder (N=3), with one
// LSB-first and one MSB-first instance sharing the same stimulus.
module tb_priority_scan_encoder;

  localparam int unsigned N = 3;
  localparam int unsigned NROWS = 25;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] in;
  logic       load_valid;
  logic       out_ready;

  logic       lr_l, ov_l, ol_l, z_l;
  logic [2:0] o_l;
  logic [3:0] c_l;
  logic       lr_m, ov_m, ol_m, z_m;
  logic [2:0] o_m;
  logic [3:0] c_m;

  int unsigned checks;
  int unsigned errors;

  typedef struct {
    logic       lv;
    logic [7:0] vin;
    logic       ord;
    logic       en;
    logic [2:0] e_out;
    logic [2:0] e_out_m;
    logic       e_valid;
    logic       e_last;
    logic       e_lr;
    logic [3:0] e_count;
    logic       e_zero;
  } row_t;

  row_t tbl [NROWS];

  priority_scan_encoder #(.N(N), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .load_valid(load_valid),
    .load_ready(lr_l), .out(o_l), .out_valid(ov_l), .out_ready(out_ready),
    .out_last(ol_l), .count(c_l), .zero(z_l)
  );

  priority_scan_encoder #(.N(N), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .load_valid(load_valid),
    .load_ready(lr_m), .out(o_m), .out_valid(ov_m), .out_ready(out_ready),
    .out_last(ol_m), .count(c_m), .zero(z_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  function automatic row_t mk(input logic lv, input logic [7:0] vin, input logic ord,
                              input logic en, input logic [2:0] eo, input logic [2:0] eom,
                              input logic ev, input logic el, input logic elr,
                              input logic [3:0] ec, input logic ez);
    row_t r;
    r.lv = lv; r.vin = vin; r.ord = ord; r.en = en;
    r.e_out = eo; r.e_out_m = eom; r.e_valid = ev; r.e_last = el;
    r.e_lr = elr; r.e_count = ec; r.e_zero = ez;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    //            lv  in     ord en  out om  vld lst lr  cnt zero
    // LSB/MSB order for 1010_0100
    tbl[0]  = mk(1, 8'hA4, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 8'hA4, 1, 1, 2, 7, 1, 0, 0, 3, 0);
    tbl[2]  = mk(0, 8'h00, 1, 1, 5, 5, 1, 0, 0, 3, 0);
    tbl[3]  = mk(0, 8'h00, 1, 1, 7, 2, 1, 1, 1, 3, 0);
    tbl[4]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    // all-zero vector: one-cycle zero pulse, no output
    tbl[5]  = mk(1, 8'h00, 1, 1, 0, 0, 0, 0, 1, 3, 0);
    tbl[6]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    // backpressure on 0001_0001
    tbl[8]  = mk(1, 8'h11, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 4, 1, 0, 0, 2, 0);
    tbl[10] = mk(0, 8'h00, 0, 1, 0, 4, 1, 0, 0, 2, 0);
    tbl[11] = mk(0, 8'h00, 0, 1, 0, 4, 1, 0, 0, 2, 0);
    tbl[12] = mk(0, 8'h00, 1, 1, 0, 4, 1, 0, 0, 2, 0);
    tbl[13] = mk(0, 8'h00, 1, 1, 4, 0, 1, 1, 1, 2, 0);
    tbl[14] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    // back-to-back load on the last beat
    tbl[15] = mk(1, 8'h01, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    tbl[16] = mk(1, 8'h80, 1, 1, 0, 0, 1, 1, 1, 1, 0);
    tbl[17] = mk(0, 8'h80, 1, 1, 7, 7, 1, 1, 1, 1, 0);
    tbl[18] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    // 0xFF with an enable gap
    tbl[19] = mk(1, 8'hFF, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    tbl[20] = mk(0, 8'h00, 1, 1, 0, 7, 1, 0, 0, 8, 0);
    tbl[21] = mk(0, 8'h00, 1, 1, 1, 6, 1, 0, 0, 8, 0);
    tbl[22] = mk(1, 8'h03, 1, 0, 2, 5, 0, 0, 0, 8, 0);
    tbl[23] = mk(1, 8'h03, 1, 0, 2, 5, 0, 0, 0, 8, 0);
    tbl[24] = mk(0, 8'h00, 0, 1, 2, 5, 1, 0, 0, 8, 0);

    rst = 1'b1; enable = 1'b1; in = 8'h00; load_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_out_valid", -1, 32'(ov_l), 0);
    chk("reset_load_ready", -1, 32'(lr_l), 1);
    chk("reset_count", -1, 32'(c_l), 0);
    chk("reset_zero", -1, 32'(z_l), 0);
    chk("reset_out", -1, 32'(o_l), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < int'(NROWS); r++) begin
      load_valid = tbl[r].lv;
      in         = tbl[r].vin;
      out_ready  = tbl[r].ord;
      enable     = tbl[r].en;
      #1;
      chk("out_lsb",        r, 32'(o_l),  32'(tbl[r].e_out));
      chk("out_msb",        r, 32'(o_m),  32'(tbl[r].e_out_m));
      chk("out_valid_lsb",  r, 32'(ov_l), 32'(tbl[r].e_valid));
      chk("out_valid_msb",  r, 32'(ov_m), 32'(tbl[r].e_valid));
      chk("out_last_lsb",   r, 32'(ol_l), 32'(tbl[r].e_last));
      chk("out_last_msb",   r, 32'(ol_m), 32'(tbl[r].e_last));
      chk("load_ready_lsb", r, 32'(lr_l), 32'(tbl[r].e_lr));
      chk("count_lsb",      r, 32'(c_l),  32'(tbl[r].e_count));
      chk("count_msb",      r, 32'(c_m),  32'(tbl[r].e_count));
      chk("zero_lsb",       r, 32'(z_l),  32'(tbl[r].e_zero));
      @(negedge clk);
    end

    // After row 24's beat (ready was 0) pending still holds 2..7; reset mid-cycle.
    load_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    chk("prereset_valid", 100, 32'(ov_l), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midscan_out_valid", 101, 32'(ov_l), 0);
    chk("midscan_load_ready", 101, 32'(lr_l), 1);
    chk("midscan_out", 101, 32'(o_l), 0);
    chk("midscan_out_msb", 101, 32'(o_m), 0);
    chk("midscan_count", 101, 32'(c_l), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_valid", 102, 32'(ov_l), 0);
    chk("post_reset_last", 102, 32'(ol_l), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
